// File: rtl/data_memory_ctrl.sv
// Byte-writable synchronous data memory with post-reset zero-fill sequencer and registered read.
// Optional macro DMEM_BYPASS_EN: same-cycle read+write returns the merged (write-first) word.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_INIT  | zero-fill sequencer running, one word per edge; Busy=1
// S_READY | accepting one read and/or write request per cycle
module data_memory_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              MR,
  input  logic              MW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WD,
  input  logic [DATA_W/8-1:0] BE,
  output logic [DATA_W-1:0] RD,
  output logic              RDValid,
  output logic              Busy,
  output logic              Err
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rdvalid_q, rdvalid_d;
  logic              err_q, err_d;
  logic              init_we, wr_en, in_range;
  logic [DATA_W-1:0] old_word, rd_src;

  logic [DATA_W-1:0] mem [DEPTH];

  assign in_range = ({1'b0, Addr} < DEPTH_C);
  assign old_word = mem[Addr];

  always_comb begin
    rd_src = old_word;
`ifdef DMEM_BYPASS_EN
    if (MW) begin
      for (int i = 0; i < NB; i++) begin
        if (BE[i]) rd_src[8*i +: 8] = WD[8*i +: 8];
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    rdvalid_d = 1'b0;
    err_d     = 1'b0;
    init_we   = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      S_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_C) state_d = S_READY;
      end
      S_READY: begin
        if ((MR || MW) && !in_range) begin
          err_d = 1'b1;
        end else begin
          wr_en = MW;
          if (MR) begin
            rdvalid_d = 1'b1;
            rd_d      = rd_src;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      rd_q      <= '0;
      rdvalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      rdvalid_q <= rdvalid_d;
      err_q     <= err_d;
    end
  end

  // Array has no reset; contents are defined only once the sequencer has swept it.
  always_ff @(posedge Clk) begin
    if (init_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (BE[i]) mem[Addr][8*i +: 8] <= WD[8*i +: 8];
      end
    end
  end

  assign RD      = rd_q;
  assign RDValid = rdvalid_q;
  assign Err     = err_q;
  assign Busy    = (state_q == S_INIT);

endmodule
